text_console_ctrl: RTL and testbench

//   Text-console sequencer for the HDMI character buffer write port (wen/write_addr/write_data).

---
 rtl/text_console_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_text_console_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/text_console_ctrl.sv
// Text console sequencer: turns an ASCII byte stream into character-buffer
// writes, tracking a cursor and handling CR, LF, BS, FF and line wrap.
module text_console_ctrl #(
    parameter int          COLS   = 32,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 10,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      in_valid,
    input  logic [7:0]                in_data,
    output logic                      in_ready,
    output logic                      wen,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [7:0]                write_data,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      busy
);

    localparam int CW    = $clog2(COLS);
    localparam int RW    = $clog2(ROWS);
    localparam int TOTAL = COLS * ROWS;

    localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(TOTAL - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [CW-1:0]     LAST_COL = CW'(COLS - 1);
    localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);

    if (COLS * ROWS > 2 ** ADDR_W) begin : g_size_err
        $error("text_console_ctrl: COLS*ROWS exceeds write_addr range");
    end

    typedef enum logic [1:0] {
        CLR_SCREEN,
        IDLE,
        CLR_LINE
    } state_t;

    state_t             state, state_d;
    logic [CW-1:0]      col, col_d;
    logic [RW-1:0]      row, row_d;
    logic               wen_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [7:0]         data_d;
    logic [ADDR_W-1:0]  clr_addr, clr_addr_d;
    logic [ADDR_W-1:0]  clr_end, clr_end_d;
    logic               clr_done, clr_done_d;

    logic [RW-1:0]      row_inc;
    logic [ADDR_W-1:0]  cur_addr;
    logic [ADDR_W-1:0]  inc_base;
    logic               is_print;

    assign row_inc  = (row == LAST_ROW) ? '0 : row + RW'(1);
    assign cur_addr = COLS_A * ADDR_W'(row) + ADDR_W'(col);
    assign inc_base = COLS_A * ADDR_W'(row_inc);
    assign is_print = (in_data >= 8'h20) && (in_data <= 8'h7E);

    assign in_ready   = (state == IDLE);
    assign busy       = ~in_ready;
    assign cursor_col = col;
    assign cursor_row = row;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= CLR_SCREEN;
            col        <= '0;
            row        <= '0;
            wen        <= 1'b0;
            write_addr <= '0;
            write_data <= '0;
            clr_addr   <= '0;
            clr_end    <= LAST_A;
            clr_done   <= 1'b0;
        end else begin
            state      <= state_d;
            col        <= col_d;
            row        <= row_d;
            wen        <= wen_d;
            write_addr <= addr_d;
            write_data <= data_d;
            clr_addr   <= clr_addr_d;
            clr_end    <= clr_end_d;
            clr_done   <= clr_done_d;
        end
    end

    always_comb begin
        state_d    = state;
        col_d      = col;
        row_d      = row;
        wen_d      = 1'b0;
        addr_d     = write_addr;
        data_d     = write_data;
        clr_addr_d = clr_addr;
        clr_end_d  = clr_end;
        clr_done_d = clr_done;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    unique case (1'b1)
                        is_print: begin
                            wen_d  = 1'b1;
                            addr_d = cur_addr;
                            data_d = in_data;
                            if (col == LAST_COL) begin
                                col_d      = '0;
                                row_d      = row_inc;
                                state_d    = CLR_LINE;
                                clr_addr_d = inc_base;
                                clr_end_d  = inc_base + COLS_A - ONE_A;
                                clr_done_d = 1'b0;
                            end else begin
                                col_d = col + CW'(1);
                            end
                        end
                        (in_data == 8'h0D): begin
                            col_d = '0;
                        end
                        // LF issues the first blank itself; the clear state does the rest
                        (in_data == 8'h0A): begin
                            col_d      = '0;
                            row_d      = row_inc;
                            wen_d      = 1'b1;
                            addr_d     = inc_base;
                            data_d     = BLANK;
                            state_d    = CLR_LINE;
                            clr_addr_d = inc_base + ONE_A;
                            clr_end_d  = inc_base + COLS_A - ONE_A;
                            clr_done_d = 1'b0;
                        end
                        (in_data == 8'h08): begin
                            if (col != '0) begin
                                col_d  = col - CW'(1);
                                wen_d  = 1'b1;
                                addr_d = cur_addr - ONE_A;
                                data_d = BLANK;
                            end
                        end
                        (in_data == 8'h0C): begin
                            col_d      = '0;
                            row_d      = '0;
                            wen_d      = 1'b1;
                            addr_d     = '0;
                            data_d     = BLANK;
                            state_d    = CLR_SCREEN;
                            clr_addr_d = ONE_A;
                            clr_end_d  = LAST_A;
                            clr_done_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            CLR_SCREEN, CLR_LINE: begin
                // one idle cycle after the final blank before accepting input
                if (clr_done) begin
                    state_d    = IDLE;
                    clr_done_d = 1'b0;
                    if (state == CLR_SCREEN) begin
                        col_d = '0;
                        row_d = '0;
                    end
                end else begin
                    wen_d  = 1'b1;
                    addr_d = clr_addr;
                    data_d = BLANK;
                    if (clr_addr == clr_end) begin
                        clr_done_d = 1'b1;
                    end else begin
                        clr_addr_d = clr_addr + ONE_A;
                    end
                end
            end
            default: state_d = CLR_SCREEN;
        endcase
    end

endmodule

// File: tb/tb_text_console_ctrl.sv
// Scoreboard bench for text_console_ctrl: stimulus pushes expected buffer
// writes, a negedge monitor pops and compares every wen cycle.
module tb_text_console_ctrl;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wen;
    logic [9:0] write_addr;
    logic [7:0] write_data;
    logic [4:0] cursor_col;
    logic [4:0] cursor_row;
    logic       busy;

    always #5 clk = ~clk;

    text_console_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .wen        (wen),
        .write_addr (write_addr),
        .write_data (write_data),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    int n_pass  = 0;
    int n_total = 0;
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    endtask

    task automatic push_w(input int addr, input int data);
        exp_q.push_back({10'(addr), 8'(data)});
    endtask

    task automatic push_line(input int r);
        for (int c = 0; c < 32; c++) push_w(r * 32 + c, 'h20);
    endtask

    task automatic push_screen();
        for (int a = 0; a < 960; a++) push_w(a, 'h20);
    endtask

    always @(negedge clk) begin
        if (wen) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_write actual=addr %0d data 0x%0h required=no write",
                         write_addr, write_data);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                chk($sformatf("write_at_%0d", e[17:8]),
                    int'({write_addr, write_data}), int'(e));
            end
        end
    end

    task automatic send(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL send_timeout actual=in_ready 0 required=in_ready 1 byte=0x%0h", b);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic release_reset(input string name);
        @(negedge clk);
        resetn = 1'b1;
        repeat (960) @(posedge clk);
        @(negedge clk);
        chk({name, "_ready_at_960"}, int'(in_ready), 0);
        @(negedge clk);
        chk({name, "_ready_at_961"}, int'(in_ready), 1);
    endtask

    initial begin
        int n;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", int'(wen), 0);
        chk("rst_addr", int'(write_addr), 0);
        chk("rst_data", int'(write_data), 0);
        chk("rst_ready", int'(in_ready), 0);
        chk("rst_busy", int'(busy), 1);
        chk("rst_col", int'(cursor_col), 0);
        chk("rst_row", int'(cursor_row), 0);

        // T1: power-up screen clear
        push_screen();
        release_reset("t1");
        chk("t1_all_writes_seen", exp_q.size(), 0);

        // T2: "AB", CR, "C"
        push_w(0, 'h41);
        push_w(1, 'h42);
        send(8'h41);
        send(8'h42);
        send(8'h0D);
        chk("t2_cr_col", int'(cursor_col), 0);
        push_w(0, 'h43);
        send(8'h43);
        chk("t2_col", int'(cursor_col), 1);
        chk("t2_row", int'(cursor_row), 0);

        // T3: full line of 'x' wraps and blanks row 1
        send(8'h0D);
        for (int i = 0; i < 32; i++) push_w(i, 'h78);
        push_line(1);
        for (int i = 0; i < 32; i++) send(8'h78);
        chk("t3_wrap_col", int'(cursor_col), 0);
        chk("t3_wrap_row", int'(cursor_row), 1);
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("t3_busy_cycles", n, 33);

        // T4: LF from last row wraps to row 0
        for (int r = 2; r < 30; r++) begin
            push_line(r);
            send(8'h0A);
        end
        for (int c = 0; c < 5; c++) begin
            push_w(928 + c, 'h61 + c);
            send(8'(8'h61 + c));
        end
        chk("t4_pre_col", int'(cursor_col), 5);
        chk("t4_pre_row", int'(cursor_row), 29);
        push_line(0);
        send(8'h0A);
        chk("t4_lf_col", int'(cursor_col), 0);
        chk("t4_lf_row", int'(cursor_row), 0);
        chk("t4_lf_busy", int'(busy), 1);
        push_w(0, 'h5A);
        send(8'h5A);
        chk("t4_z_col", int'(cursor_col), 1);

        // T5: backspace and ignored control bytes
        send(8'h0D);
        send(8'h08);
        chk("t5_bs0_wen", int'(wen), 0);
        chk("t5_bs0_col", int'(cursor_col), 0);
        send(8'h07);
        chk("t5_bel_wen", int'(wen), 0);
        chk("t5_bel_ready", int'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            push_w(c, 'h61 + c);
            send(8'(8'h61 + c));
        end
        push_w(3, 'h51);
        send(8'h51);
        chk("t5_q_col", int'(cursor_col), 4);
        push_w(3, 'h20);
        send(8'h08);
        chk("t5_bs_col", int'(cursor_col), 3);
        chk("t5_bs_row", int'(cursor_row), 0);

        // T6: FF, then reset mid-clear
        push_screen();
        send(8'h0C);
        chk("t6_ff_col", int'(cursor_col), 0);
        chk("t6_ff_row", int'(cursor_row), 0);
        chk("t6_ff_busy", int'(busy), 1);
        n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (!(wen && write_addr == 10'd400) && n < 2000);
        chk("t6_reached_400", int'(write_addr), 400);
        resetn = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        chk("t6_abort_wen", int'(wen), 0);
        chk("t6_abort_ready", int'(in_ready), 0);
        chk("t6_abort_addr", int'(write_addr), 0);
        push_screen();
        release_reset("t6");
        chk("t6_all_writes_seen", exp_q.size(), 0);
        push_w(0, 'h4B);
        send(8'h4B);
        chk("t6_k_col", int'(cursor_col), 1);

        repeat (5) @(negedge clk);
        chk("end_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
